// File: rtl/mem_arb_pkg.sv
// Shared types for the fetch/data memory port arbiter.
// Holds FSM state, owner encoding and counter sizing.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    RSP
  } arb_state_e;

  typedef enum logic {
    OWN_IF,
    OWN_D
  } arb_owner_e;

  function automatic int starve_cnt_w(input int limit);
    return $clog2(limit + 1);
  endfunction

endpackage

// File: rtl/mem_arb_select.sv
// Winner selection between fetch and data requests,
// with the saturating fetch-starvation counter.
module mem_arb_select
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req_i,
  input  logic d_req_i,
  input  logic arb_en_i,
  output logic win_d_o,
  output logic win_if_o
);

  localparam int CW = starve_cnt_w(STARVE_LIMIT);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          starved;

  assign starved  = if_req_i && (cnt_q == LIM);
  assign win_d_o  = arb_en_i && d_req_i && !starved;
  assign win_if_o = arb_en_i && if_req_i && !win_d_o;

  // Only data wins against a waiting fetch accumulate.
  always_comb begin
    cnt_d = cnt_q;
    if (arb_en_i) begin
      if (win_d_o && if_req_i) begin
        cnt_d = (cnt_q == LIM) ? cnt_q : cnt_q + 1'b1;
      end else begin
        cnt_d = '0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between fetch and data/LSU,
// one outstanding access, responses routed to the issuer.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DWIDTH       = 32,
  parameter int AWIDTH       = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req_i,
  input  logic [AWIDTH-1:0]   if_addr_i,
  output logic                if_gnt_o,
  output logic                if_rvalid_o,
  output logic [DWIDTH-1:0]   if_rdata_o,
  input  logic                d_req_i,
  input  logic                d_we_i,
  input  logic [AWIDTH-1:0]   d_addr_i,
  input  logic [DWIDTH-1:0]   d_wdata_i,
  input  logic [DWIDTH/8-1:0] d_be_i,
  output logic                d_gnt_o,
  output logic                d_rvalid_o,
  output logic [DWIDTH-1:0]   d_rdata_o,
  output logic                mem_req_o,
  output logic                mem_we_o,
  output logic [AWIDTH-1:0]   mem_addr_o,
  output logic [DWIDTH-1:0]   mem_wdata_o,
  output logic [DWIDTH/8-1:0] mem_be_o,
  input  logic                mem_gnt_i,
  input  logic                mem_rvalid_i,
  input  logic [DWIDTH-1:0]   mem_rdata_i
);

  arb_state_e          state_q;
  arb_owner_e          owner_q;
  logic                req_q;
  logic                we_q;
  logic [AWIDTH-1:0]   addr_q;
  logic [DWIDTH-1:0]   wdata_q;
  logic [DWIDTH/8-1:0] be_q;

  logic arb_en;
  logic win_d;
  logic win_if;
  logic in_req;
  logic in_rsp;
  logic own_d;

  assign arb_en = (state_q == IDLE);
  assign in_req = (state_q == REQ);
  assign in_rsp = (state_q == RSP);
  assign own_d  = (owner_q == OWN_D);

  mem_arb_select #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_sel (
    .clk     (clk),
    .rst     (rst),
    .if_req_i(if_req_i),
    .d_req_i (d_req_i),
    .arb_en_i(arb_en),
    .win_d_o (win_d),
    .win_if_o(win_if)
  );

  // Request fields are captured once at arbitration and
  // held untouched until the memory accepts them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      owner_q <= OWN_IF;
      req_q   <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (win_d) begin
            owner_q <= OWN_D;
            req_q   <= 1'b1;
            we_q    <= d_we_i;
            addr_q  <= d_addr_i;
            wdata_q <= d_wdata_i;
            be_q    <= d_be_i;
            state_q <= REQ;
          end else if (win_if) begin
            owner_q <= OWN_IF;
            req_q   <= 1'b1;
            we_q    <= 1'b0;
            addr_q  <= if_addr_i;
            wdata_q <= '0;
            be_q    <= '1;
            state_q <= REQ;
          end
        end
        REQ: begin
          if (mem_gnt_i) begin
            req_q   <= 1'b0;
            state_q <= RSP;
          end
        end
        RSP: begin
          if (mem_rvalid_i) begin
            state_q <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign mem_req_o   = req_q;
  assign mem_we_o    = we_q;
  assign mem_addr_o  = addr_q;
  assign mem_wdata_o = wdata_q;
  assign mem_be_o    = be_q;

  assign if_gnt_o = in_req && mem_gnt_i && !own_d;
  assign d_gnt_o  = in_req && mem_gnt_i && own_d;

  // Responses outside RSP are stray and never forwarded.
  assign if_rvalid_o = in_rsp && !own_d && mem_rvalid_i;
  assign d_rvalid_o  = in_rsp && own_d && mem_rvalid_i;
  assign if_rdata_o  = (in_rsp && !own_d) ? mem_rdata_i : '0;
  assign d_rdata_o   = (in_rsp && own_d) ? mem_rdata_i : '0;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single instruction/data memory port between two requesters: the fetch stage (read-only) and the data/LSU path (read/write).
- Sits between the core stages and the memory model.
- Serializes transactions with one outstanding access, gives data priority, and bounds fetch starvation with a counter.
- Routes each memory response back to the requester that issued it.

Parameters:
- DWIDTH, 32, data bus width.
- AWIDTH, 32, address bus width.
- STARVE_LIMIT, 4, consecutive data grants allowed while fetch waits (must be >= 1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous reset, active-high.
- if_req_i  in  1  fetch read request; held until if_gnt_o.
- if_addr_i  in  AWIDTH  fetch address.
- if_gnt_o  out  1  fetch request accepted by memory (1-cycle pulse).
- if_rvalid_o  out  1  fetch read data valid (1-cycle pulse).
- if_rdata_o  out  DWIDTH  fetch read data.
- d_req_i  in  1  data request; held until d_gnt_o.
- d_we_i  in  1  data write enable (1 = store).
- d_addr_i  in  AWIDTH  data address.
- d_wdata_i  in  DWIDTH  store data.
- d_be_i  in  DWIDTH/8  store byte enables.
- d_gnt_o  out  1  data request accepted (1-cycle pulse).
- d_rvalid_o  out  1  data response valid; load data or store ack.
- d_rdata_o  out  DWIDTH  load data.
- mem_req_o  out  1  memory request.
- mem_we_o  out  1  memory write enable.
- mem_addr_o  out  AWIDTH  memory address.
- mem_wdata_o  out  DWIDTH  memory write data.
- mem_be_o  out  DWIDTH/8  memory byte enables.
- mem_gnt_i  in  1  memory accepts the request this cycle.
- mem_rvalid_i  in  1  memory response valid; one per accepted request, for reads and writes.
- mem_rdata_i  in  DWIDTH  memory read data.

Behaviour:
- Clock and reset: single clock clk; rst is asynchronous, active-high.
- Reset values:
  - state = IDLE, owner = IF, starve_cnt = 0.
  - mem_req_o, mem_we_o = 0; mem_addr_o, mem_wdata_o, mem_be_o = 0.
  - All gnt_o/rvalid_o outputs = 0.
- States: IDLE, REQ, RSP.
- IDLE, arbitration:
  - If d_req_i && !(if_req_i && starve_cnt == STARVE_LIMIT): data wins.
  - Else if if_req_i: fetch wins.
  - Else: stay in IDLE.
  - The winner's address, we, wdata and be are latched into the mem_* registers, owner is recorded, state -> REQ.
  - A fetch win drives mem_we_o = 0, mem_be_o = all ones, mem_wdata_o = 0.
- Starvation counter (updated on the arbitration cycle only):
  - Data win while if_req_i = 1: starve_cnt + 1.
  - Fetch win, or if_req_i = 0: starve_cnt cleared to 0.
  - Saturates at STARVE_LIMIT.
- REQ:
  - mem_req_o = 1; mem_* held stable until mem_gnt_i.
  - On mem_gnt_i: the owner's gnt_o pulses combinationally in that same cycle, mem_req_o deasserts next cycle, state -> RSP.
  - The non-owner's gnt_o is never asserted.
- RSP:
  - Owner's rvalid_o = mem_rvalid_i and rdata_o = mem_rdata_i (combinational pass-through). Non-owner rvalid_o = 0; its rdata_o = 0.
  - On mem_rvalid_i: state -> IDLE. Arbitration resumes in the following cycle.
- Latency with zero-wait memory:
  - req seen in cycle 0 -> mem_req_o in cycle 1 -> gnt in cycle 1 -> rvalid in cycle 2 (earliest).
  - Back-to-back transactions: one every 3 cycles.
- Requester inputs changing after the latch (before gnt) are ignored; requesters must hold req, which the bench checks.
- mem_rvalid_i while in IDLE or REQ is dropped: no rvalid_o is forwarded.
- Reset mid-transaction (REQ or RSP) aborts the transaction: all outputs return to reset values immediately, and any late mem_rvalid_i afterwards is dropped.
- Simultaneous requests with starve_cnt < STARVE_LIMIT: data wins.

Decomposition:
- Package mem_arb_pkg:
  - enum arb_state_e {IDLE, REQ, RSP}.
  - enum arb_owner_e {OWN_IF, OWN_D}.
  - Function for starve counter width: $clog2(STARVE_LIMIT+1).
- One sub-module, mem_arb_select: combinational winner selection plus the registered starvation counter. Inputs: if_req, d_req, arb_en. Outputs: win_d, win_if.
- Top level holds the FSM, the request registers and the response mux.

Test Plan:
- Fetch only: if_req_i=1, addr 0x01000000, mem_gnt_i=1 tied, rvalid one cycle after gnt with rdata 0x00000013 -> mem_addr_o=0x01000000 and mem_we_o=0 in cycle 1; if_gnt_o in cycle 1; if_rvalid_o=1 with 0x00000013 in cycle 2; d_* outputs stay 0.
- Data store: d_we_i=1, addr 0x01000100, wdata 0xDEADBEEF, be 4'b0011 -> mem_* match exactly; d_gnt_o pulse; d_rvalid_o ack; if_rvalid_o stays 0.
- Simultaneous requests at IDLE (fetch 0x01000004, load 0x01000200) -> load served first; fetch is granted on the next arbitration, 3 cycles later.
- Starvation: d_req_i and if_req_i held high continuously -> grant order D,D,D,D,IF,D,...; starve_cnt reaches 4, then clears to 0 after the fetch win.
- Delayed memory: mem_gnt_i low for 5 cycles in REQ with d_addr_i changed mid-wait -> mem_req_o held high; mem_addr_o keeps the latched value; exactly one d_gnt_o pulse.
- Reset mid-RSP, then a stray mem_rvalid_i=1 -> all outputs 0 immediately; stray response not forwarded; a new fetch completes normally.
